// File: rtl/mul_seq.sv
// Sequential unsigned shift-and-add multiplier: one BUS_WIDTH ripple adder
// reused over BUS_WIDTH iterations, with a start/busy/done handshake.

module add #(
  parameter int BUS_WIDTH = 16
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  output logic [BUS_WIDTH-1:0] sum,
  output logic                 carry
);
  always_comb begin
    {carry, sum} = {1'b0, a} + {1'b0, b};
  end
endmodule

module mul_seq #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BUS_WIDTH-1:0]   a,
  input  logic [BUS_WIDTH-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [2*BUS_WIDTH-1:0] product
);
  localparam int CW = $clog2(BUS_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [BUS_WIDTH-1:0]   m;
  logic [BUS_WIDTH-1:0]   hi;
  logic [BUS_WIDTH-1:0]   lo;
  logic [CW-1:0]          cnt;
  logic [BUS_WIDTH-1:0]   addend;
  logic [BUS_WIDTH-1:0]   sum;
  logic                   carry;
  logic [2*BUS_WIDTH-1:0] shifted;

  always_comb begin
    addend  = lo[0] ? m : '0;
    // Carry-out lands in the top bit, so the product never overflows.
    shifted = {carry, sum, lo[BUS_WIDTH-1:1]};
  end

  add #(.BUS_WIDTH(BUS_WIDTH)) u_add (
    .a     (hi),
    .b     (addend),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m       <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          {hi, lo} <= shifted;
          cnt      <= cnt + CW'(1);
          if (cnt == CW'(BUS_WIDTH - 1)) begin
            product <= shifted;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          // Accepting here gives one result every BUS_WIDTH+1 cycles.
          if (start) begin
            m     <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: cycle-level behavioural model plus
// directed and randomized operations.

module tb_mul_seq;
  localparam int W   = 16;
  localparam int LAT = W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;

  mul_seq #(.BUS_WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Model: counts down the remaining edges of an accepted operation.
  int             rem = 0;
  logic [W-1:0]   op_a = '0;
  logic [W-1:0]   op_b = '0;
  logic           exp_busy = 1'b0;
  logic           exp_done = 1'b0;
  logic [2*W-1:0] exp_prod = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem = 0; exp_busy = 1'b0; exp_done = 1'b0; exp_prod = '0;
    end else if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) begin
        exp_prod = (2*W)'(op_a) * (2*W)'(op_b);
        exp_done = 1'b1;
        exp_busy = 1'b0;
      end
    end else begin
      exp_done = 1'b0;
      if (start) begin
        op_a = a; op_b = b; rem = LAT; exp_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks = checks + 3;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy t=%0t got %b expected %b", $time, busy, exp_busy);
      end
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done t=%0t got %b expected %b", $time, done, exp_done);
      end
      if (product !== exp_prod) begin
        errors++;
        $display("FAIL product t=%0t got %h expected %h", $time, product, exp_prod);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns the number of negedges until done is seen
  // (17 = done in the cycle after the 16th edge following acceptance).
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input bit hold, input bit scramble, output int lat);
    start = 1'b1; a = va; b = vb;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (hold) begin
        a = '1; b = '1;
      end else if (scramble) begin
        a = W'($urandom); b = W'($urandom); start = $urandom_range(0, 1) == 1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    start = 1'b0;
    if (lat >= 100) begin
      errors++;
      $display("FAIL timeout waiting for done got %0d cycles expected %0d", lat, LAT + 1);
    end
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb;

    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_done", 64'(done), 0);
    chk("reset_product", 64'(product), 0);
    rst = 1'b0;

    @(negedge clk);
    chk("t1_busy_idle", 64'(busy), 0);
    issue(3, 5, 1'b0, 1'b0, lat);
    chk("t1_latency", 64'(lat - 1), 64'(LAT));
    chk("t1_product", 64'(product), 64'h0000000F);
    chk("t1_model", 64'(exp_prod), 64'h0000000F);
    @(negedge clk);
    chk("t1_done_width", 64'(done), 0);
    chk("t1_held", 64'(product), 64'h0000000F);

    @(negedge clk);
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, lat);
    chk("t2_ffff", 64'(product), 64'hFFFE0001);
    chk("t2_model", 64'(exp_prod), 64'hFFFE0001);
    @(negedge clk);
    issue(0, 16'h1234, 1'b0, 1'b0, lat);
    chk("t2_zero", 64'(product), 0);

    @(negedge clk);
    issue(7, 9, 1'b1, 1'b0, lat);
    chk("t3_latency", 64'(lat - 1), 64'(LAT));
    chk("t3_product", 64'(product), 64'h0000003F);

    issue(16'h1000, 16'h0010, 1'b0, 1'b0, lat);
    chk("t4_gap", 64'(lat), 64'(LAT + 1));
    chk("t4_product", 64'(product), 64'h00010000);

    @(negedge clk);
    start = 1'b1; a = 16'hABCD; b = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_busy", 64'(busy), 0);
    chk("t5_done", 64'(done), 0);
    chk("t5_product", 64'(product), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_no_done", 64'(done), 0);
    issue(2, 3, 1'b0, 1'b0, lat);
    chk("t5_after", 64'(product), 64'd6);

    for (int i = 0; i < 1000; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      ra = W'($urandom); rb = W'($urandom);
      if ((i % 50) == 0) ra = '1;
      issue(ra, rb, 1'b0, ($urandom_range(0, 3) == 0), lat);
      chk("rnd_product", 64'(product), 64'((2*W)'(ra) * (2*W)'(rb)));
      if (gap == 0 && i > 0) chk("rnd_gap", 64'(lat), 64'(LAT + 1));
      else chk("rnd_latency", 64'(lat - 1), 64'(LAT));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
